pic_inta_sequencer: RTL and testbench
=====================================

// Module: pic_inta_sequencer
// PURPOSE
//  Interrupt-acknowledge controller for the 8259A-style PIC. It sits between the priority
//  resolver/ISR datapath and the CPU INTA bus.
//  - Raises INT.
//  - Runs the two-pulse 8086 INTA cycle.
//  - Latches the winning IR into the ISR.
//  - Drives the cascade address (master) or answers its cascade ID (slave).
//  - Puts the vector on the data bus; issues an automatic EOI clear when AEOI is set.
// PARAMETERS
//  N_IR    8  interrupt levels (fixed 8 for 8259A compatibility)
//  CAS_W   3  cascade address width
// PORTS
//  clk         in   1     system clock
//  rst         in   1     asynchronous, active-high reset
//  pr_valid    in   1     resolver has a pending unmasked request above current ISR priority
//  pr_vector   in   8     one-hot winning IR from resolver (valid when pr_valid)
//  icw2_base   in   5     vector base T7..T3 from ICW2
//  icw3_cfg    in   8     master: slave-present bitmap; slave: [2:0] = own ID
//  sp_en       in   1     1 = master, 0 = slave
//  aeoi        in   1     automatic EOI mode (ICW4)
//  inta_n      in   1     CPU acknowledge, active low, synchronous to clk
//  cas_in      in   3     cascade lines from master (slave mode)
//  int_out     out  1     interrupt request to CPU / master IR pin
//  isr_set     out  8     one-cycle one-hot pulse: set ISR bit
//  isr_clr     out  8     one-cycle one-hot pulse: clear ISR bit (AEOI)
//  cas_out     out  3     cascade address driven by master
//  cas_oe      out  1     cascade output enable
//  data_out    out  8     vector byte
//  data_oe     out  1     data bus output enable
// BEHAVIOUR
//  Reset (async):
//  - All outputs 0; state IDLE; inta_q = 1.
//  - Mid-cycle reset abandons the INTA cycle with no ISR pulse.
//  Edge detection:
//  - inta_fall = inta_q & ~inta_n; inta_rise = ~inta_q & inta_n; inta_q is registered inta_n.
//  Index encoding:
//  - idx = binary encode of the latched one-hot sel; spurious idx = 7.
//  States: IDLE, REQ, ACK1, WAIT2, ACK2.
//  - IDLE:
//    - pr_valid -> REQ; int_out = 1 from the next cycle (1-cycle latency).
//  - REQ:
//    - int_out held.
//    - inta_fall -> ACK1; int_out = 0; sel <= pr_vector.
//    - If pr_valid has dropped by the fall: spurious cycle, sel = IR7, no isr_set.
//    - Master, non-spurious: isr_set = sel for one cycle at this transition.
//  - ACK1:
//    - Master with icw3_cfg[idx] = 1: cas_oe = 1, cas_out = idx; held until the ACK2 exit.
//    - inta_rise -> WAIT2.
//    - Slave: samples cas_in on this edge.
//      - Match to icw3_cfg[2:0] and non-spurious: isr_set = sel pulse, responder = 1.
//      - Otherwise -> IDLE with no pulse and no drive.
//  - WAIT2:
//    - inta_fall -> ACK2.
//  - ACK2:
//    - data_oe = 1, data_out = {icw2_base, idx} iff responder.
//    - Responder = slave with matched ID, or master whose icw3_cfg[idx] = 0.
//    - Master that cascaded never drives data.
//    - inta_rise -> IDLE; data_oe and cas_oe low from the next cycle.
//    - If aeoi and non-spurious: isr_clr = sel pulse on the rise cycle.
//  Config sampling:
//  - icw2_base / icw3_cfg are sampled combinationally in ACK2 and ACK1 respectively.
//  - sel is frozen from the first fall, so resolver changes mid-cycle are ignored.
//  Simultaneous events:
//  - pr_valid rising in the same cycle as inta_fall in IDLE is ignored (no INT was raised).
//  - After IDLE re-entry, a still-pending request re-raises INT 1 cycle later.
//  Out-of-order INTA:
//  - inta_rise in REQ, or inta_fall in ACK1, is ignored.
//  - No timeout; the CPU owns protocol correctness.
//  Data bus:
//  - data_out = 0 whenever data_oe = 0.
// STRUCTURE
//  Shared package pic_pkg:
//  - state localparams (IDLE..ACK2)
//  - SPURIOUS_IDX = 3'd7
//  - onehot-to-binary function
//  - widths N_IR, CAS_W
//  Sub-module pic_inta_edge: inta_n register plus rise/fall pulse generation.
//  FSM, responder logic and output registers live in this module.
// TESTING
//  1. Master, no cascade: pr_vector=8'h08, base=5'h10, aeoi=0, two INTA pulses
//     -> int_out=1 one cycle after pr_valid; isr_set=8'h08 at first fall;
//        data_out=8'h83 with data_oe=1 during the second pulse; isr_clr stays 0.
//  2. Master cascade: icw3_cfg=8'h04, pr_vector=8'h04
//     -> cas_oe=1, cas_out=3'd2 from first fall to second rise; data_oe never 1.
//  3. Slave: icw3_cfg[2:0]=3'd5, cas_in=5 (then repeat with cas_in=3)
//     -> cas_in=5: isr_set on first rise, vector driven on second pulse;
//        cas_in=3: returns to IDLE with no pulses and no drive.
//  4. Spurious: pr_valid drops before first fall
//     -> no isr_set; data_out={base,3'd7}; AEOI gives no isr_clr.
//  5. AEOI=1, pr_vector=8'h01 -> isr_clr=8'h01 pulse on the second-rise cycle.
//  6. Reset asserted in WAIT2
//     -> all outputs 0 immediately; with the request still pending,
//        int_out re-asserts 1 cycle after release.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared definitions for the PIC interrupt-acknowledge sequencer:
// widths, FSM state encoding and the one-hot to binary IR encoder.
package pic_pkg;

  localparam int N_IR  = 8;
  localparam int CAS_W = 3;

  // Index reported when the request vanished before the first INTA fall.
  localparam logic [CAS_W-1:0] SPURIOUS_IDX = 3'd7;
  localparam logic [N_IR-1:0]  SPURIOUS_SEL = N_IR'(1) << SPURIOUS_IDX;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ACK1,
    WAIT2,
    ACK2
  } state_t;

  // Binary index of a one-hot IR vector (bits are OR-ed, so a zero vector gives 0).
  function automatic logic [CAS_W-1:0] onehot_to_bin(input logic [N_IR-1:0] v);
    logic [CAS_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_IR; i++) begin
      if (v[i]) r = r | CAS_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/pic_inta_edge.sv
// Registers the CPU INTA strobe and produces single-cycle fall/rise pulses.
module pic_inta_edge (
  input  logic clk,
  input  logic rst,
  input  logic inta_n,
  output logic inta_fall,
  output logic inta_rise
);

  logic inta_q;

  // Previous-cycle copy of inta_n; idles high so reset never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) inta_q <= 1'b1;
    else     inta_q <= inta_n;
  end

  assign inta_fall = inta_q & ~inta_n;
  assign inta_rise = ~inta_q & inta_n;

endmodule

// File: rtl/pic_inta_sequencer.sv
// 8259A-style interrupt-acknowledge controller: raises INT, follows the
// two-pulse 8086 INTA cycle, pulses ISR set/clear, handles cascade
// addressing (master) or cascade ID matching (slave), and drives the vector.
module pic_inta_sequencer
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       pr_valid,
  input  logic [7:0] pr_vector,
  input  logic [4:0] icw2_base,
  input  logic [7:0] icw3_cfg,
  input  logic       sp_en,
  input  logic       aeoi,
  input  logic       inta_n,
  input  logic [2:0] cas_in,
  output logic       int_out,
  output logic [7:0] isr_set,
  output logic [7:0] isr_clr,
  output logic [2:0] cas_out,
  output logic       cas_oe,
  output logic [7:0] data_out,
  output logic       data_oe
);

  logic inta_fall;
  logic inta_rise;

  pic_inta_edge u_edge (
    .clk       (clk),
    .rst       (rst),
    .inta_n    (inta_n),
    .inta_fall (inta_fall),
    .inta_rise (inta_rise)
  );

  state_t          state_q;
  logic [N_IR-1:0] sel_q;
  logic            spurious_q;
  logic            responder_q;

  logic            int_out_q;
  logic [N_IR-1:0] isr_set_q;
  logic [N_IR-1:0] isr_clr_q;
  logic [CAS_W-1:0] cas_out_q;
  logic            cas_oe_q;
  logic [7:0]      data_out_q;
  logic            data_oe_q;

  // Selection as it would be latched on the first fall, and derived indices.
  logic [N_IR-1:0]  sel_d;
  logic [CAS_W-1:0] idx_d;
  logic [CAS_W-1:0] idx;
  logic             cas_hit_d;
  logic             cas_hit;
  logic             id_match;
  logic [7:0]       vector;

  // Decode selection, cascade decisions and vector byte from current inputs.
  always_comb begin
    sel_d     = pr_valid ? pr_vector : SPURIOUS_SEL;
    idx_d     = onehot_to_bin(sel_d);
    idx       = onehot_to_bin(sel_q);
    cas_hit_d = sp_en & icw3_cfg[idx_d];
    cas_hit   = sp_en & icw3_cfg[idx];
    id_match  = (cas_in == icw3_cfg[CAS_W-1:0]);
    vector    = {icw2_base, idx};
  end

  // INTA sequencing FSM with all bus outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      spurious_q  <= 1'b0;
      responder_q <= 1'b0;
      int_out_q   <= 1'b0;
      isr_set_q   <= '0;
      isr_clr_q   <= '0;
      cas_out_q   <= '0;
      cas_oe_q    <= 1'b0;
      data_out_q  <= '0;
      data_oe_q   <= 1'b0;
    end else begin
      isr_set_q <= '0;
      isr_clr_q <= '0;
      case (state_q)
        IDLE: begin
          // A fall with no INT raised yet is not our acknowledge.
          if (pr_valid && !inta_fall) begin
            state_q   <= REQ;
            int_out_q <= 1'b1;
          end
        end
        REQ: begin
          if (inta_fall) begin
            state_q    <= ACK1;
            int_out_q  <= 1'b0;
            sel_q      <= sel_d;
            spurious_q <= ~pr_valid;
            if (sp_en && pr_valid) isr_set_q <= pr_vector;
            cas_oe_q   <= cas_hit_d;
            cas_out_q  <= cas_hit_d ? idx_d : '0;
          end
        end
        ACK1: begin
          cas_oe_q  <= cas_hit;
          cas_out_q <= cas_hit ? idx : '0;
          if (inta_rise) begin
            if (sp_en) begin
              state_q     <= WAIT2;
              responder_q <= ~cas_hit;
            end else if (id_match && !spurious_q) begin
              state_q     <= WAIT2;
              responder_q <= 1'b1;
              isr_set_q   <= sel_q;
            end else begin
              state_q     <= IDLE;
              responder_q <= 1'b0;
            end
          end
        end
        WAIT2: begin
          if (inta_fall) begin
            state_q    <= ACK2;
            data_oe_q  <= responder_q;
            data_out_q <= responder_q ? vector : '0;
          end
        end
        ACK2: begin
          if (inta_rise) begin
            state_q     <= IDLE;
            responder_q <= 1'b0;
            data_oe_q   <= 1'b0;
            data_out_q  <= '0;
            cas_oe_q    <= 1'b0;
            cas_out_q   <= '0;
            if (aeoi && !spurious_q) isr_clr_q <= sel_q;
          end else begin
            data_oe_q  <= responder_q;
            data_out_q <= responder_q ? vector : '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign int_out  = int_out_q;
  assign isr_set  = isr_set_q;
  assign isr_clr  = isr_clr_q;
  assign cas_out  = cas_out_q;
  assign cas_oe   = cas_oe_q;
  assign data_out = data_out_q;
  assign data_oe  = data_oe_q;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Directed bench for the INTA sequencer: master, cascade, slave, spurious,
// AEOI and mid-cycle reset scenarios with hand-computed expectations.
module tb_pic_inta_sequencer;

  logic       clk;
  logic       rst;
  logic       pr_valid;
  logic [7:0] pr_vector;
  logic [4:0] icw2_base;
  logic [7:0] icw3_cfg;
  logic       sp_en;
  logic       aeoi;
  logic       inta_n;
  logic [2:0] cas_in;
  logic       int_out;
  logic [7:0] isr_set;
  logic [7:0] isr_clr;
  logic [2:0] cas_out;
  logic       cas_oe;
  logic [7:0] data_out;
  logic       data_oe;

  int errors = 0;
  int checks = 0;

  pic_inta_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .pr_valid  (pr_valid),
    .pr_vector (pr_vector),
    .icw2_base (icw2_base),
    .icw3_cfg  (icw3_cfg),
    .sp_en     (sp_en),
    .aeoi      (aeoi),
    .inta_n    (inta_n),
    .cas_in    (cas_in),
    .int_out   (int_out),
    .isr_set   (isr_set),
    .isr_clr   (isr_clr),
    .cas_out   (cas_out),
    .cas_oe    (cas_oe),
    .data_out  (data_out),
    .data_oe   (data_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and land on the following falling edge.
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; pr_valid = 1'b0; pr_vector = 8'h00; icw2_base = 5'h10;
    icw3_cfg = 8'h00; sp_en = 1'b1; aeoi = 1'b0; inta_n = 1'b1; cas_in = 3'd0;
    tick(2);
    check("rst_int_out", 32'(int_out), 32'h0);
    check("rst_isr_set", 32'(isr_set), 32'h0);
    check("rst_isr_clr", 32'(isr_clr), 32'h0);
    check("rst_cas_oe", 32'(cas_oe), 32'h0);
    check("rst_cas_out", 32'(cas_out), 32'h0);
    check("rst_data_oe", 32'(data_oe), 32'h0);
    check("rst_data_out", 32'(data_out), 32'h0);
    rst = 1'b0;
    tick(1);
    check("idle_int_out", 32'(int_out), 32'h0);

    // 1. Master, no cascade, IR3, base 0x10 -> vector 0x83
    pr_valid = 1'b1; pr_vector = 8'h08;
    tick(1);
    check("t1_int_out", 32'(int_out), 32'h1);
    inta_n = 1'b0; tick(1);
    check("t1_isr_set", 32'(isr_set), 32'h08);
    check("t1_int_drop", 32'(int_out), 32'h0);
    tick(1);
    check("t1_isr_set_1cyc", 32'(isr_set), 32'h00);
    inta_n = 1'b1; tick(1);
    check("t1_wait_data_oe", 32'(data_oe), 32'h0);
    tick(1);
    inta_n = 1'b0; tick(1);
    check("t1_data_oe", 32'(data_oe), 32'h1);
    check("t1_data_out", 32'(data_out), 32'h83);
    check("t1_cas_oe", 32'(cas_oe), 32'h0);
    inta_n = 1'b1; pr_valid = 1'b0; tick(1);
    check("t1_data_oe_off", 32'(data_oe), 32'h0);
    check("t1_data_out_off", 32'(data_out), 32'h00);
    check("t1_isr_clr", 32'(isr_clr), 32'h00);
    tick(1);
    check("t1_idle", 32'(int_out), 32'h0);

    // 2. Master cascade: slave on IR2
    icw3_cfg = 8'h04; pr_valid = 1'b1; pr_vector = 8'h04;
    tick(1);
    check("t2_int_out", 32'(int_out), 32'h1);
    inta_n = 1'b0; tick(1);
    check("t2_cas_oe", 32'(cas_oe), 32'h1);
    check("t2_cas_out", 32'(cas_out), 32'h2);
    check("t2_isr_set", 32'(isr_set), 32'h04);
    inta_n = 1'b1; tick(1);
    check("t2_cas_oe_wait", 32'(cas_oe), 32'h1);
    inta_n = 1'b0; tick(1);
    check("t2_data_oe", 32'(data_oe), 32'h0);
    check("t2_data_out", 32'(data_out), 32'h00);
    check("t2_cas_oe_ack2", 32'(cas_oe), 32'h1);
    check("t2_cas_out_ack2", 32'(cas_out), 32'h2);
    inta_n = 1'b1; pr_valid = 1'b0; tick(1);
    check("t2_cas_oe_off", 32'(cas_oe), 32'h0);
    check("t2_cas_out_off", 32'(cas_out), 32'h0);
    check("t2_data_oe_end", 32'(data_oe), 32'h0);

    // 3a. Slave ID 5, matching cascade address, IR1, base 0x08 -> vector 0x41
    sp_en = 1'b0; icw3_cfg = 8'h05; icw2_base = 5'h08; cas_in = 3'd5;
    pr_valid = 1'b1; pr_vector = 8'h02;
    tick(1);
    check("t3_int_out", 32'(int_out), 32'h1);
    inta_n = 1'b0; tick(1);
    check("t3_no_set_at_fall", 32'(isr_set), 32'h00);
    check("t3_cas_oe", 32'(cas_oe), 32'h0);
    inta_n = 1'b1; tick(1);
    check("t3_isr_set", 32'(isr_set), 32'h02);
    inta_n = 1'b0; tick(1);
    check("t3_data_oe", 32'(data_oe), 32'h1);
    check("t3_data_out", 32'(data_out), 32'h41);
    inta_n = 1'b1; pr_valid = 1'b0; tick(1);
    check("t3_data_oe_off", 32'(data_oe), 32'h0);

    // 3b. Slave ID 5, cascade address 3 -> not addressed
    cas_in = 3'd3; pr_valid = 1'b1;
    tick(1);
    inta_n = 1'b0; tick(1);
    check("t3b_no_set_fall", 32'(isr_set), 32'h00);
    inta_n = 1'b1; pr_valid = 1'b0; tick(1);
    check("t3b_no_set_rise", 32'(isr_set), 32'h00);
    inta_n = 1'b0; tick(1);
    check("t3b_data_oe", 32'(data_oe), 32'h0);
    check("t3b_data_out", 32'(data_out), 32'h00);
    inta_n = 1'b1; tick(1);
    check("t3b_int_out", 32'(int_out), 32'h0);

    // 4. Spurious on master with AEOI: request drops before first fall
    sp_en = 1'b1; icw3_cfg = 8'h00; icw2_base = 5'h10; aeoi = 1'b1;
    pr_valid = 1'b1; pr_vector = 8'h08;
    tick(1);
    pr_valid = 1'b0; tick(1);
    check("t4_int_held", 32'(int_out), 32'h1);
    inta_n = 1'b0; tick(1);
    check("t4_no_isr_set", 32'(isr_set), 32'h00);
    inta_n = 1'b1; tick(1);
    inta_n = 1'b0; tick(1);
    check("t4_data_oe", 32'(data_oe), 32'h1);
    check("t4_data_out", 32'(data_out), 32'h87);
    inta_n = 1'b1; tick(1);
    check("t4_no_isr_clr", 32'(isr_clr), 32'h00);

    // 5. AEOI on IR0
    pr_valid = 1'b1; pr_vector = 8'h01;
    tick(1);
    inta_n = 1'b0; tick(1);
    check("t5_isr_set", 32'(isr_set), 32'h01);
    inta_n = 1'b1; tick(1);
    inta_n = 1'b0; tick(1);
    check("t5_data_out", 32'(data_out), 32'h80);
    check("t5_isr_clr_early", 32'(isr_clr), 32'h00);
    inta_n = 1'b1; pr_valid = 1'b0; tick(1);
    check("t5_isr_clr", 32'(isr_clr), 32'h01);
    tick(1);
    check("t5_isr_clr_1cyc", 32'(isr_clr), 32'h00);

    // 6. Reset in WAIT2 while cascading on IR3
    aeoi = 1'b0; icw3_cfg = 8'h08; pr_valid = 1'b1; pr_vector = 8'h08;
    tick(1);
    inta_n = 1'b0; tick(1);
    inta_n = 1'b1; tick(1);
    check("t6_cas_oe_pre", 32'(cas_oe), 32'h1);
    check("t6_cas_out_pre", 32'(cas_out), 32'h3);
    rst = 1'b1; #1;
    check("t6_cas_oe_rst", 32'(cas_oe), 32'h0);
    check("t6_cas_out_rst", 32'(cas_out), 32'h0);
    check("t6_int_out_rst", 32'(int_out), 32'h0);
    tick(1);
    check("t6_int_held_low", 32'(int_out), 32'h0);
    rst = 1'b0; tick(1);
    check("t6_int_reassert", 32'(int_out), 32'h1);
    check("t6_no_isr_set", 32'(isr_set), 32'h00);
    check("t6_data_oe", 32'(data_oe), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
